// File: rtl/flow_pifo_ctrl.sv
// flow_pifo_ctrl
// Controller in front of a single flow-level PIFO. Round-robin arbitration
// shares the PIFO enqueue port among NUM_REQ requesters. Dequeues feed a
// registered valid/ready egress stage. Occupancy is tracked locally, and a
// flush sequence (RUN -> FLUSH -> DONE -> RUN) drains the PIFO back to empty.
//
// Optional build macro: FLOW_PIFO_CTRL_STATS_EN adds the statistics outputs
//   o__stat_enq_total, o__stat_deq_total and o__stat_peak_occ.
//
// Ports
//   clk, reset (async, active-high)
//   i__req_valid/priority/pointer : per-requester enqueue (slice k = requester k)
//   o__req_ready                  : one-hot grant
//   o__pifo_enqueue/priority/pointer, o__pifo_dequeue : PIFO control
//   i__pifo_full/empty/priority/pointer               : PIFO status and head
//   o__out_valid/priority/pointer, i__out_ready       : egress stage
//   i__flush, o__flush_done       : flush request and completion pulse
//   o__occupancy                  : entries currently held in the PIFO
module flow_pifo_ctrl #(
  parameter int NUM_REQ    = 4,
  parameter int CAPACITY   = 16,
  parameter int PRIO_WIDTH = 8,
  parameter int PTR_WIDTH  = 10
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              i__req_valid,
  input  logic [NUM_REQ*PRIO_WIDTH-1:0]   i__req_priority,
  input  logic [NUM_REQ*PTR_WIDTH-1:0]    i__req_pointer,
  output logic [NUM_REQ-1:0]              o__req_ready,
  output logic                            o__pifo_enqueue,
  output logic [PRIO_WIDTH-1:0]           o__pifo_priority,
  output logic [PTR_WIDTH-1:0]            o__pifo_pointer,
  output logic                            o__pifo_dequeue,
  input  logic                            i__pifo_full,
  input  logic                            i__pifo_empty,
  input  logic [PRIO_WIDTH-1:0]           i__pifo_priority,
  input  logic [PTR_WIDTH-1:0]            i__pifo_pointer,
  output logic                            o__out_valid,
  output logic [PRIO_WIDTH-1:0]           o__out_priority,
  output logic [PTR_WIDTH-1:0]            o__out_pointer,
  input  logic                            i__out_ready,
  input  logic                            i__flush,
  output logic                            o__flush_done,
`ifdef FLOW_PIFO_CTRL_STATS_EN
  output logic [31:0]                     o__stat_enq_total,
  output logic [31:0]                     o__stat_deq_total,
  output logic [$clog2(CAPACITY+1)-1:0]   o__stat_peak_occ,
`endif
  output logic [$clog2(CAPACITY+1)-1:0]   o__occupancy
);

  localparam int OCC_W = $clog2(CAPACITY + 1);
  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [IDX_W-1:0]      r_rr_ptr;
  logic [OCC_W-1:0]      r_occ;
  logic [OCC_W-1:0]      w_occ_next;
  logic                  r_out_valid;
  logic [PRIO_WIDTH-1:0] r_out_prio;
  logic [PTR_WIDTH-1:0]  r_out_ptr;

  logic [NUM_REQ-1:0]    w_grant;
  logic                  w_found;
  logic [IDX_W-1:0]      w_winner;
  int unsigned           w_idx;
  logic                  w_pop_run;
  logic                  w_deq;
  logic                  w_done;

  // Round-robin scan starting at r_rr_ptr; the first valid requester wins.
  always_comb begin
    w_grant  = '0;
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = 0;
    if (r_state == ST_RUN && !i__pifo_full) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        w_idx = (32'(r_rr_ptr) + i) % NUM_REQ;
        if (!w_found && i__req_valid[w_idx]) begin
          w_found         = 1'b1;
          w_winner        = w_idx[IDX_W-1:0];
          w_grant[w_idx]  = 1'b1;
        end
      end
    end
  end

  assign o__req_ready     = w_grant;
  assign o__pifo_enqueue  = w_found;
  assign o__pifo_priority = i__req_priority[w_winner*PRIO_WIDTH +: PRIO_WIDTH];
  assign o__pifo_pointer  = i__req_pointer[w_winner*PTR_WIDTH +: PTR_WIDTH];

  // Pop whenever the egress register is free or being drained this cycle.
  assign w_pop_run = (r_state == ST_RUN) && !i__pifo_empty &&
                     (!r_out_valid || i__out_ready);

  always_comb begin
    w_state_next = r_state;
    w_deq        = 1'b0;
    w_done       = 1'b0;
    unique case (r_state)
      ST_RUN: begin
        w_deq = w_pop_run;
        if (i__flush) w_state_next = ST_FLUSH;
      end
      ST_FLUSH: begin
        w_deq = !i__pifo_empty;
        if (i__pifo_empty && r_occ == '0) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        w_done       = 1'b1;
        w_state_next = ST_RUN;
      end
      default: w_state_next = ST_RUN;
    endcase
  end

  assign o__pifo_dequeue = w_deq;
  assign o__flush_done   = w_done;

  always_comb begin
    w_occ_next = r_occ;
    unique case ({w_found, w_deq})
      2'b10:   w_occ_next = r_occ + OCC_W'(1);
      2'b01:   w_occ_next = r_occ - OCC_W'(1);
      default: w_occ_next = r_occ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_RUN;
      r_rr_ptr <= '0;
      r_occ    <= '0;
    end else begin
      r_state <= w_state_next;
      r_occ   <= w_occ_next;
      if (w_found)
        r_rr_ptr <= (w_winner == IDX_W'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;
    end
  end

  // A flush request takes precedence: the pending entry and any head popped
  // in the same cycle are both discarded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_prio  <= '0;
      r_out_ptr   <= '0;
    end else if (r_state == ST_RUN && i__flush) begin
      r_out_valid <= 1'b0;
    end else if (w_pop_run) begin
      r_out_valid <= 1'b1;
      r_out_prio  <= i__pifo_priority;
      r_out_ptr   <= i__pifo_pointer;
    end else if (r_out_valid && i__out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign o__out_valid    = r_out_valid;
  assign o__out_priority = r_out_prio;
  assign o__out_pointer  = r_out_ptr;
  assign o__occupancy    = r_occ;

`ifdef FLOW_PIFO_CTRL_STATS_EN
  logic [31:0]      r_enq_total;
  logic [31:0]      r_deq_total;
  logic [OCC_W-1:0] r_peak_occ;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_enq_total <= '0;
      r_deq_total <= '0;
      r_peak_occ  <= '0;
    end else begin
      if (w_found) r_enq_total <= r_enq_total + 32'd1;
      if (r_out_valid && i__out_ready) r_deq_total <= r_deq_total + 32'd1;
      if (w_occ_next > r_peak_occ) r_peak_occ <= w_occ_next;
    end
  end

  assign o__stat_enq_total = r_enq_total;
  assign o__stat_deq_total = r_deq_total;
  assign o__stat_peak_occ  = r_peak_occ;
`endif

endmodule
